sub_serial: RTL

SUB_SERIAL -- requirements
Module: sub_serial

---
 rtl/sub_pkg.sv | 21 ++
 rtl/sub_slice.sv | 26 ++
 rtl/sub_serial.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  // Operation phases: waiting for operands, rippling slices, holding result.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefSlice = 4;

  // Counter width for n slices; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CntWidth = cnt_width(DefWidth / DefSlice);

endpackage

// File: rtl/sub_slice.sv
// Combinational SLICE-bit ripple-borrow subtract cell.
module sub_slice #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             bin_i,
  output logic [SLICE-1:0] d_o,
  output logic             bout_o
);

  logic [SLICE:0] br;

  // Ripple the borrow from bit 0 upward through the slice.
  always_comb begin
    br     = '0;
    d_o    = '0;
    br[0]  = bin_i;
    for (int i = 0; i < int'(SLICE); i++) begin
      d_o[i]  = a_i[i] ^ b_i[i] ^ br[i];
      br[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & br[i]);
    end
    bout_o = br[SLICE];
  end

endmodule

// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor: computes a - b one SLICE per cycle with a
// valid/ready handshake on both operand and result sides.
// WIDTH must be an integer multiple of SLICE.
module sub_serial
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SLICE = DefSlice
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned NumSlices = WIDTH / SLICE;
  localparam int unsigned CntW      = cnt_width(NumSlices);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSlices - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bin_q, bin_d;
  // Set once the last slice is written; the following edge enters StDone.
  logic             fin_q, fin_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;

  logic [31:0]      base;
  logic [SLICE-1:0] sl_a, sl_b, sl_d;
  logic             sl_bout;

  // Select the operand slice addressed by the counter.
  always_comb begin
    base = 32'(cnt_q) * SLICE;
    sl_a = a_q[base +: SLICE];
    sl_b = b_q[base +: SLICE];
  end

  sub_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .bin_i  (bin_q),
    .d_o    (sl_d),
    .bout_o (sl_bout)
  );

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    diff_d     = diff_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    fin_d      = fin_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          bin_d   = 1'b0;
          fin_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (fin_q) begin
          borrow_d   = bin_q;
          overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff_q[WIDTH-1] != a_q[WIDTH-1]);
          state_d    = StDone;
        end else begin
          diff_d[base +: SLICE] = sl_d;
          bin_d                 = sl_bout;
          if (cnt_q == LastCnt) begin
            fin_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      diff_q     <= '0;
      cnt_q      <= '0;
      bin_q      <= 1'b0;
      fin_q      <= 1'b0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      diff_q     <= diff_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      fin_q      <= fin_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign overflow  = overflow_q;

endmodule
